t_ff_counter: RTL

//   Parametrised WIDTH-bit register bank built from per-bit T flip-flops with a synchronous clear.

---
 rtl/t_ff_pkg.sv | 11 +
 rtl/t_ff_cell.sv | 33 +++
 rtl/t_ff_counter.sv | 94 +++++++++
 3 files changed

// File: rtl/t_ff_pkg.sv
// Shared definitions for the T flip-flop counter bank.
//   MODE_* : encodings of the 2-bit mode input
//            (toggle by mask, count up, count down, parallel load).
package t_ff_pkg;

   localparam logic [1:0] MODE_TOGGLE = 2'b00;
   localparam logic [1:0] MODE_UP     = 2'b01;
   localparam logic [1:0] MODE_DOWN   = 2'b10;
   localparam logic [1:0] MODE_LOAD   = 2'b11;

endpackage

// File: rtl/t_ff_cell.sv
// Single T flip-flop with synchronous clear and parallel load.
// Ports:
//   clk : clock, state updates on posedge
//   clr : synchronous active-high clear (q=0, qb=1), highest priority
//   t   : toggle request
//   ld  : load d into q, overrides t
//   d   : load data
//   q   : registered state
//   qb  : registered complement of q (its own flop, not an inverter)
module t_ff_cell (
   input  logic clk,
   input  logic clr,
   input  logic t,
   input  logic ld,
   input  logic d,
   output logic q,
   output logic qb
);

   always_ff @(posedge clk) begin
      if (clr) begin
         q  <= 1'b0;
         qb <= 1'b1;
      end else if (ld) begin
         q  <= d;
         qb <= ~d;
      end else if (t) begin
         q  <= ~q;
         qb <= ~qb;
      end
   end

endmodule

// File: rtl/t_ff_counter.sv
// WIDTH-bit register bank built from per-bit T flip-flops.
// Modes: toggle by mask, binary up count, binary down count, parallel load.
// Ports:
//   clk    : clock
//   clr    : synchronous active-high clear, overrides everything
//   en     : operation enable, 0 holds state and forces wrap low
//   mode   : 00 toggle, 01 up, 10 down, 11 load
//   t_mask : per-bit toggle request (toggle mode)
//   d      : parallel load value (load mode)
//   q, qb  : state and registered complement
//   wrap   : one-cycle pulse after an edge on which the count wrapped
module t_ff_counter
   import t_ff_pkg::*;
#(
   parameter int WIDTH    = 8,
   parameter bit SATURATE = 1'b0
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             en,
   input  logic [1:0]       mode,
   input  logic [WIDTH-1:0] t_mask,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] qb,
   output logic             wrap
);

   logic [WIDTH-1:0] up_chain;
   logic [WIDTH-1:0] dn_chain;
   logic [WIDTH-1:0] t_vec;
   logic             all_ones;
   logic             all_zero;
   logic             ld;
   logic             wrap_next;

   // Bit i toggles when every lower bit is 1 (up) or 0 (down). Each term is
   // formed directly from q with a low-bit mask rather than chained from the
   // previous term, so the comb logic has no self-referencing vector.
   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      localparam logic [WIDTH-1:0] LOW = WIDTH'((64'd1 << i) - 64'd1);

      assign up_chain[i] = &(q | ~LOW);
      assign dn_chain[i] = ~|(q & LOW);

      t_ff_cell u_cell (
         .clk (clk),
         .clr (clr),
         .t   (t_vec[i]),
         .ld  (ld),
         .d   (d[i]),
         .q   (q[i]),
         .qb  (qb[i])
      );
   end

   assign all_ones = &q;
   assign all_zero = ~|q;

   always_comb begin
      t_vec     = '0;
      ld        = 1'b0;
      wrap_next = 1'b0;
      if (en) begin
         case (mode)
            MODE_TOGGLE: t_vec = t_mask;
            MODE_UP: begin
               // saturate gate: at the top the whole toggle vector is dropped
               if (!(SATURATE && all_ones)) begin
                  t_vec     = up_chain;
                  wrap_next = all_ones;
               end
            end
            MODE_DOWN: begin
               if (!(SATURATE && all_zero)) begin
                  t_vec     = dn_chain;
                  wrap_next = all_zero;
               end
            end
            MODE_LOAD: ld = 1'b1;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         wrap <= 1'b0;
      end else begin
         wrap <= wrap_next;
      end
   end

endmodule
